// File: rtl/dsp_path_router_pkg.sv
// Shared types and constants for the DSP path router: FSM states, source
// indices and the width arithmetic used by the per-channel scaler.
package dsp_path_pkg;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    RUN      = 2'd1,
    FADE_OUT = 2'd2,
    SWITCH   = 2'd3
  } state_t;

  localparam int MODE_ADC        = 0;
  localparam int MODE_CORDIC     = 1;
  localparam int MODE_FULL       = 2;
  localparam int MODE_ADC_CORDIC = 3;
  localparam int MODE_GEN        = 4;

  // Right shift that brings a sample*gain product back down to the DAC width.
  function automatic int scale_shift(input int iw, input int dw, input int gw);
    return gw + iw - dw;
  endfunction

endpackage

// File: rtl/dsp_path_router_if.sv
// Source-side and DAC-side signal bundle of the DSP path router.
interface dsp_path_router_if #(
  parameter int NCH  = 2,
  parameter int NSRC = 5,
  parameter int IW   = 16,
  parameter int DW   = 14,
  parameter int MW   = 3
);
  // Strobe handshake, no back-pressure: a sample moves on every clock where
  // its src_valid bit is high, dac_valid marks exactly one output word, and a
  // one-cycle mode_stb is answered by mode_busy rising or a mode_err pulse.
  logic [NSRC*NCH*IW-1:0] src_data;
  logic [NSRC-1:0]        src_valid;
  logic [MW-1:0]          mode_req;
  logic                   mode_stb;
  logic                   fmt_offset;
  logic [MW-1:0]          mode_cur;
  logic                   mode_busy;
  logic                   mode_err;
  logic [NCH*DW-1:0]      dac_data;
  logic                   dac_valid;

  modport master (
    output src_data, src_valid, mode_req, mode_stb, fmt_offset,
    input  mode_cur, mode_busy, mode_err, dac_data, dac_valid
  );

  modport slave (
    input  src_data, src_valid, mode_req, mode_stb, fmt_offset,
    output mode_cur, mode_busy, mode_err, dac_data, dac_valid
  );
endinterface

// File: rtl/dsp_path_scale.sv
// One output channel: gain multiply (S2), then round-half-up, saturate to
// DAC width and optional offset-binary flip (S3).
module dsp_path_scale
  import dsp_path_pkg::*;
#(
  parameter int IW = 16,
  parameter int DW = 14,
  parameter int GW = 6
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 en_s2,
  input  logic                 en_s3,
  input  logic signed [IW-1:0] sample,
  input  logic [GW:0]          gain,
  input  logic                 fmt_offset,
  output logic [DW-1:0]        word
);
  localparam int PW = IW + GW + 2;
  localparam int SH = scale_shift(IW, DW, GW);
  localparam logic signed [PW-1:0] RND    = PW'(1) << (SH - 1);
  localparam logic signed [PW-1:0] SAT_HI = (PW'(1) << (DW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [DW-1:0] W_HI = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] W_LO = {1'b1, {(DW-1){1'b0}}};

  logic signed [PW-1:0] samp_ext, gain_ext, prod_q, prod_d, rnd, shifted;
  logic [DW-1:0]        sat, word_q, word_d;

  always_comb begin
    samp_ext = {{(PW-IW){sample[IW-1]}}, sample};
    gain_ext = {{(PW-GW-1){1'b0}}, gain};
    prod_d   = en_s2 ? samp_ext * gain_ext : prod_q;
    rnd      = prod_q + RND;
    shifted  = rnd >>> SH;
    // Only positive full scale can round past the top of the DAC range.
    if (shifted > SAT_HI)      sat = W_HI;
    else if (shifted < SAT_LO) sat = W_LO;
    else                       sat = shifted[DW-1:0];
    word_d = en_s3 ? (sat ^ {fmt_offset, {(DW-1){1'b0}}}) : word_q;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      word_q <= '0;
    end else begin
      prod_q <= prod_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
endmodule

// File: rtl/dsp_path_router.sv
// Source selector in front of the DAC: click-free fade-out/switch/fade-in on
// every mode change, then per-channel gain, round, saturate and format.
module dsp_path_router
  import dsp_path_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int NSRC = 5,
  parameter int IW   = 16,
  parameter int DW   = 14,
  parameter int GW   = 6,
  parameter int MW   = 3
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  dsp_path_router_if.slave bus,
  output state_t           fsm_state
);
  localparam logic [GW:0] GAIN_MAX = {1'b1, {GW{1'b0}}};

  state_t               state_q, state_d;
  logic [GW:0]          gain_q, gain_d;
  logic [MW-1:0]        mode_cur_q, mode_cur_d, mode_pend_q, mode_pend_d;
  logic                 err_q, err_d, req_ok;
  logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                 s3_valid_q, s3_valid_d;
  logic signed [IW-1:0] s1_data_q [NCH];
  logic signed [IW-1:0] s1_data_d [NCH];
  logic [DW-1:0]        dac_word  [NCH];

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    mode_cur_d  = mode_cur_q;
    mode_pend_d = mode_pend_q;
    req_ok      = (int'(bus.mode_req) < NSRC);
    // Requests are only taken in RUN; anything else is dropped and flagged.
    err_d       = bus.mode_stb && ((state_q != RUN) || !req_ok);
    case (state_q)
      FADE_IN: begin
        if (gain_q < GAIN_MAX) gain_d = gain_q + 1'b1;
        if (gain_d == GAIN_MAX) state_d = RUN;
      end
      RUN: begin
        if (bus.mode_stb && req_ok) begin
          mode_pend_d = bus.mode_req;
          state_d     = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (gain_q != '0) gain_d = gain_q - 1'b1;
        if (gain_d == '0) state_d = SWITCH;
      end
      SWITCH: begin
        mode_cur_d = mode_pend_q;
        state_d    = FADE_IN;
      end
      default: state_d = FADE_IN;
    endcase
  end

  always_comb begin
    s1_valid_d = bus.src_valid[mode_cur_q];
    for (int c = 0; c < NCH; c++) begin
      s1_data_d[c] = s1_valid_d ? bus.src_data[(int'(mode_cur_q)*NCH + c)*IW +: IW]
                                : s1_data_q[c];
    end
    s2_valid_d = s1_valid_q;
    s3_valid_d = s2_valid_q;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FADE_IN;
      gain_q      <= '0;
      mode_cur_q  <= '0;
      mode_pend_q <= '0;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      for (int c = 0; c < NCH; c++) s1_data_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      mode_cur_q  <= mode_cur_d;
      mode_pend_q <= mode_pend_d;
      err_q       <= err_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      for (int c = 0; c < NCH; c++) s1_data_q[c] <= s1_data_d[c];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dsp_path_scale #(.IW(IW), .DW(DW), .GW(GW)) u_scale (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .en_s2      (s1_valid_q),
      .en_s3      (s2_valid_q),
      .sample     (s1_data_q[c]),
      .gain       (gain_q),
      .fmt_offset (bus.fmt_offset),
      .word       (dac_word[c])
    );
    assign bus.dac_data[c*DW +: DW] = dac_word[c];
  end

  assign bus.mode_cur  = mode_cur_q;
  assign bus.mode_busy = (state_q != RUN);
  assign bus.mode_err  = err_q;
  assign bus.dac_valid = s3_valid_q;
  assign fsm_state     = state_q;
endmodule

// File: tb/tb_dsp_path_router.sv
// Directed bench for dsp_path_router: expected DAC words are queued as
// samples are driven and checked by an independent monitor.
module tb_dsp_path_router;
  import dsp_path_pkg::*;

  localparam int NCH = 2, NSRC = 5, IW = 16, DW = 14, GW = 6, MW = 3;
  localparam int W = NCH * DW;

  logic   sys_clk = 1'b0;
  logic   rst_n   = 1'b0;
  state_t fsm_state;
  int     checks  = 0;
  int     errors  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  // Source s channel c carries k*256, so at gain g the DAC word is exactly k*g.
  int k_tab [NSRC][NCH] = '{'{64, -64}, '{10, -10}, '{16, -1}, '{5, 7}, '{3, -3}};

  dsp_path_router_if #(.NCH(NCH), .NSRC(NSRC), .IW(IW), .DW(DW), .MW(MW)) bus ();

  dsp_path_router #(.NCH(NCH), .NSRC(NSRC), .IW(IW), .DW(DW), .GW(GW), .MW(MW)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int src, input int g);
    logic [W-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*DW +: DW] = DW'(k_tab[src][c] * g);
    return w;
  endfunction

  // Gain seen by a sample captured j edges after a switch request edge.
  function automatic int g_at(input int j);
    if (j <= 0)   return 64;
    if (j <= 64)  return 64 - j;
    if (j == 65)  return 0;
    if (j <= 129) return j - 65;
    return 64;
  endfunction

  // Driver tasks
  task automatic load_table();
    for (int s = 0; s < NSRC; s++)
      for (int c = 0; c < NCH; c++)
        bus.src_data[(s*NCH + c)*IW +: IW] = IW'(k_tab[s][c] * 256);
  endtask

  task automatic step(input bit v, input int g, input int src);
    bus.src_valid = {NSRC{v}};
    if (v) exp_q.push_back(exp_word(src, g));
    @(negedge sys_clk);
  endtask

  task automatic step_raw(input logic [IW-1:0] d0, input logic [IW-1:0] d1,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    bus.src_data[(2*NCH + 0)*IW +: IW] = d0;
    bus.src_data[(2*NCH + 1)*IW +: IW] = d1;
    bus.src_valid = '1;
    exp_q.push_back({e1, e0});
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (rst_n && bus.dac_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dac_unexpected: got %h with no expected word queued", bus.dac_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.dac_data !== exp_w) begin
          errors++;
          $display("FAIL dac_data: got %h expected %h", bus.dac_data, exp_w);
        end
      end
    end
  end

  initial begin
    bus.src_valid  = '0;
    bus.mode_req   = '0;
    bus.mode_stb   = 1'b0;
    bus.fmt_offset = 1'b0;
    load_table();
    repeat (2) @(negedge sys_clk);
    check("rst_mode_cur", 32'(bus.mode_cur), 0);
    check("rst_busy", 32'(bus.mode_busy), 1);
    check("rst_err", 32'(bus.mode_err), 0);
    check("rst_dac_data", 32'(bus.dac_data), 0);
    check("rst_dac_valid", 32'(bus.dac_valid), 0);
    check("rst_state", 32'(fsm_state), 32'(FADE_IN));

    // Fade-in from reset on source 0
    rst_n = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      step(1'b1, (n < 64) ? n : 64, 0);
      if (n == 63) check("fadein_busy_63", 32'(bus.mode_busy), 1);
      if (n == 64) check("fadein_busy_64", 32'(bus.mode_busy), 0);
    end

    // Out-of-range requests in RUN
    bus.mode_req = 3'd7; bus.mode_stb = 1'b1;
    step(1'b1, 64, 0);
    bus.mode_stb = 1'b0;
    check("bad7_err", 32'(bus.mode_err), 1);
    check("bad7_mode_cur", 32'(bus.mode_cur), 0);
    check("bad7_state", 32'(fsm_state), 32'(RUN));
    bus.mode_req = 3'd5; bus.mode_stb = 1'b1;
    step(1'b1, 64, 0);
    bus.mode_stb = 1'b0;
    check("bad5_err", 32'(bus.mode_err), 1);
    step(1'b1, 64, 0);
    check("bad_err_clear", 32'(bus.mode_err), 0);
    check("bad_busy", 32'(bus.mode_busy), 0);

    // Switch to source 2 with a rejected strobe during fade-out
    for (int j = 0; j <= 135; j++) begin
      if (j == 0)  begin bus.mode_req = 3'd2; bus.mode_stb = 1'b1; end
      if (j == 10) begin bus.mode_req = 3'd4; bus.mode_stb = 1'b1; end
      step(1'b1, g_at(j), (j <= 65) ? 0 : 2);
      bus.mode_stb = 1'b0;
      if (j == 0)   check("sw_busy_start", 32'(bus.mode_busy), 1);
      if (j == 0)   check("sw_err_none", 32'(bus.mode_err), 0);
      if (j == 10)  check("sw_busy_err", 32'(bus.mode_err), 1);
      if (j == 11)  check("sw_busy_err_clear", 32'(bus.mode_err), 0);
      if (j == 64)  check("sw_mode_old", 32'(bus.mode_cur), 0);
      if (j == 64)  check("sw_state_switch", 32'(fsm_state), 32'(SWITCH));
      if (j == 65)  check("sw_mode_new", 32'(bus.mode_cur), 2);
      if (j == 65)  check("sw_state_fadein", 32'(fsm_state), 32'(FADE_IN));
      if (j == 128) check("sw_busy_128", 32'(bus.mode_busy), 1);
      if (j == 129) check("sw_busy_129", 32'(bus.mode_busy), 0);
    end

    // Unity gain rounding, saturation and output format
    step_raw(16'h7FFF, 16'h8000, 14'h1FFF, 14'h2000);
    step_raw(16'h0002, 16'hFFFE, 14'h0001, 14'h0000);
    step_raw(16'h0006, 16'h0000, 14'h0002, 14'h0000);
    step_raw(16'h007F, 16'hFF7F, 14'h0020, 14'h3FE0);
    idle(4);
    check("hold_valid", 32'(bus.dac_valid), 0);
    check("hold_data", 32'(bus.dac_data), 32'({14'h3FE0, 14'h0020}));
    bus.fmt_offset = 1'b1;
    step_raw(16'h7FFF, 16'h8000, 14'h3FFF, 14'h0000);
    step_raw(16'h0000, 16'h0002, 14'h2000, 14'h2001);
    idle(4);
    bus.fmt_offset = 1'b0;
    load_table();

    // Asynchronous reset in the middle of a fade-out towards source 1
    for (int j = 0; j <= 20; j++) begin
      if (j == 0) begin bus.mode_req = 3'd1; bus.mode_stb = 1'b1; end
      step(1'b1, g_at(j), 2);
      bus.mode_stb = 1'b0;
    end
    check("pre_rst_state", 32'(fsm_state), 32'(FADE_OUT));
    #2 rst_n = 1'b0;
    #1;
    check("arst_dac_data", 32'(bus.dac_data), 0);
    check("arst_dac_valid", 32'(bus.dac_valid), 0);
    check("arst_mode_cur", 32'(bus.mode_cur), 0);
    check("arst_busy", 32'(bus.mode_busy), 1);
    check("arst_state", 32'(fsm_state), 32'(FADE_IN));
    exp_q.delete();
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      step(1'b1, (n < 64) ? n : 64, 0);
      if (n == 63) check("refade_busy_63", 32'(bus.mode_busy), 1);
      if (n == 64) check("refade_busy_64", 32'(bus.mode_busy), 0);
    end
    check("refade_mode_cur", 32'(bus.mode_cur), 0);
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
